// File: rtl/adma_as_atx_resp_if.sv
// Issue-side and B-channel signals of the DMA completion tracker.
// The slave modport is the tracker; the master modport is the splitter/AXI side.
interface adma_as_atx_resp_if #(
   parameter int unsigned MST_ID_W = 5,
   parameter int unsigned OUTSTD_W = 4
);
   logic [MST_ID_W-1:0] atx_id;
   logic                atx_start;
   logic                atx_start_last;
   logic                atx_issue_rdy;
   logic [MST_ID_W-1:0] bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic                tx_done_vld;
   logic                tx_done_err;
   logic                tx_done_rdy;
   logic [OUTSTD_W-1:0] outstd_cnt;
   logic                id_mismatch;

   modport slave (
      input  atx_id, atx_start, atx_start_last, bid, bresp, bvalid, tx_done_rdy,
      output atx_issue_rdy, bready, tx_done_vld, tx_done_err, outstd_cnt, id_mismatch
   );

   modport master (
      output atx_id, atx_start, atx_start_last, bid, bresp, bvalid, tx_done_rdy,
      input  atx_issue_rdy, bready, tx_done_vld, tx_done_err, outstd_cnt, id_mismatch
   );
endinterface

// File: rtl/adma_as_atx_resp.sv
// Tracks issued AXI bursts against in-order B responses and emits one completion,
// with an accumulated error bit, per DMA transaction.
module adma_as_atx_resp #(
   parameter int unsigned MST_ID_W   = 5,
   parameter int unsigned MAX_OUTSTD = 8
) (
   input logic               clk,
   input logic               rst,
   adma_as_atx_resp_if.slave bus
);
   localparam int unsigned OUTSTD_W = $clog2(MAX_OUTSTD + 1);
   localparam int unsigned PTR_W    = $clog2(MAX_OUTSTD);
   localparam logic [OUTSTD_W-1:0] MaxCnt = OUTSTD_W'(MAX_OUTSTD);

   logic [MAX_OUTSTD-1:0] flags_q, flags_d;
   logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OUTSTD_W-1:0]   cnt_q, cnt_d;
   logic                  issue_rdy_q, issue_rdy_d;
   logic                  err_acc_q, err_acc_d;
   logic                  done_vld_q, done_vld_d;
   logic                  done_err_q, done_err_d;
   logic                  mism_q, mism_d;
   logic                  empty, bready, push, pop, err, flag;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign bready = ~empty & ~done_vld_q;
   assign push   = bus.atx_start & issue_rdy_q;
   assign pop    = bus.bvalid & bready;
   assign err    = bus.bresp[1];
   assign flag   = flags_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      flags_d     = flags_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      err_acc_d   = err_acc_q;
      done_vld_d  = done_vld_q;
      done_err_d  = done_err_q;
      mism_d      = mism_q;

      if (push) begin
         flags_d[wr_ptr_q[PTR_W-1:0]] = bus.atx_start_last;
         wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + OUTSTD_W'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - OUTSTD_W'(1);
      end

      if (done_vld_q && bus.tx_done_rdy) begin
         done_vld_d = 1'b0;
         done_err_d = 1'b0;
      end
      // bready is low while a done is pending, so a pop never collides with a clear.
      if (pop) begin
         if (bus.bid != bus.atx_id) begin
            mism_d = 1'b1;
         end
         if (flag) begin
            done_vld_d = 1'b1;
            done_err_d = err_acc_q | err;
            err_acc_d  = 1'b0;
         end else begin
            err_acc_d = err_acc_q | err;
         end
      end

      issue_rdy_d = (cnt_d != MaxCnt);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         issue_rdy_q <= 1'b0;
         err_acc_q   <= 1'b0;
         done_vld_q  <= 1'b0;
         done_err_q  <= 1'b0;
         mism_q      <= 1'b0;
      end else begin
         flags_q     <= flags_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         issue_rdy_q <= issue_rdy_d;
         err_acc_q   <= err_acc_d;
         done_vld_q  <= done_vld_d;
         done_err_q  <= done_err_d;
         mism_q      <= mism_d;
      end
   end

   assign bus.atx_issue_rdy = issue_rdy_q;
   assign bus.bready        = bready;
   assign bus.tx_done_vld   = done_vld_q;
   assign bus.tx_done_err   = done_err_q;
   assign bus.outstd_cnt    = cnt_q;
   assign bus.id_mismatch   = mism_q;

   // Issuing a burst while throttled is a protocol violation by the splitter.
   a_no_issue_when_full : assert property (@(posedge clk) disable iff (rst)
      bus.atx_start |-> issue_rdy_q);
endmodule

// File: tb/tb_adma_as_atx_resp.sv
// Bench for adma_as_atx_resp: vector table, directed corner sequences and random
// traffic compared every cycle against a queue-based completion model.
module tb_adma_as_atx_resp;
   localparam int unsigned MaxOutstd = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   adma_as_atx_resp_if #(.MST_ID_W(5), .OUTSTD_W(4)) bus ();

   adma_as_atx_resp #(.MST_ID_W(5), .MAX_OUTSTD(MaxOutstd)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_pass = 0;
   int n_chk  = 0;
   int ndone  = 0;

   // Reference model: one queue entry per outstanding burst holding its "last" flag.
   bit fq[$];
   bit acc_m, dv_m, de_m, mm_m, rdy_m;

   // Inputs packed as {start, last, bvalid, bresp[1:0], bad_id, done_rdy}.
   typedef struct packed {
      logic [6:0] in;
      logic [8:0] exp;  // {cnt[3:0], issue_rdy, bready, done_vld, done_err, id_mismatch}
   } vec_t;
   vec_t tbl[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [8:0] dut_vec();
      return {bus.outstd_cnt, bus.atx_issue_rdy, bus.bready, bus.tx_done_vld,
              bus.tx_done_err, bus.id_mismatch};
   endfunction

   function automatic logic [8:0] model_vec();
      return {4'(fq.size()), rdy_m, (fq.size() != 0) && !dv_m, dv_m, de_m, mm_m};
   endfunction

   task automatic drive(input logic [6:0] v);
      bus.atx_start      = v[6];
      bus.atx_start_last = v[5];
      bus.bvalid         = v[4];
      bus.bresp          = v[3:2];
      bus.bid            = v[1] ? (bus.atx_id ^ 5'h01) : bus.atx_id;
      bus.tx_done_rdy    = v[0];
   endtask

   task automatic model_step();
      bit bhs, push, f;
      bhs  = bus.bvalid && (fq.size() != 0) && !dv_m;
      push = bus.atx_start && rdy_m;
      if (dv_m && bus.tx_done_rdy) begin
         dv_m = 1'b0;
         de_m = 1'b0;
      end
      if (bhs) begin
         f = fq.pop_front();
         if (bus.bid != bus.atx_id) mm_m = 1'b1;
         if (f) begin
            dv_m  = 1'b1;
            de_m  = acc_m | bus.bresp[1];
            acc_m = 1'b0;
         end else begin
            acc_m = acc_m | bus.bresp[1];
         end
      end
      if (push) fq.push_back(bus.atx_start_last);
      rdy_m = (fq.size() != MaxOutstd);
   endtask

   task automatic cycle();
      if (bus.tx_done_vld && bus.tx_done_rdy) ndone++;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model", 32'(dut_vec()), 32'(model_vec()));
   endtask

   task automatic apply_reset();
      drive(7'b0);
      rst = 1'b1;
      #1;
      check("rst_outputs", 32'(dut_vec()), 32'd0);
      fq.delete();
      acc_m = 1'b0; dv_m = 1'b0; de_m = 1'b0; mm_m = 1'b0; rdy_m = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle();
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && (fq.size() != 0 || dv_m); i++) begin
         drive(7'b0_0_1_00_0_1);
         cycle();
      end
      drive(7'b0);
      check("drain_empty", 32'(bus.outstd_cnt), 32'd0);
   endtask

   initial begin
      bit st, l, bv, bad, dr;
      bit [1:0] br;
      int issued;

      bus.atx_id = 5'h0A;
      drive(7'b0);
      apply_reset();
      check("rdy_after_reset", 32'(bus.atx_issue_rdy), 32'd1);

      // Single burst, three-burst error accumulation, EXOKAY, DECERR with bad BID.
      tbl[0]  = '{7'b1_1_0_00_0_0, 9'b0001_1_1_0_0_0};
      tbl[1]  = '{7'b0_0_1_00_0_0, 9'b0000_1_0_1_0_0};
      tbl[2]  = '{7'b0_0_0_00_0_1, 9'b0000_1_0_0_0_0};
      tbl[3]  = '{7'b1_0_0_00_0_0, 9'b0001_1_1_0_0_0};
      tbl[4]  = '{7'b1_0_1_00_0_0, 9'b0001_1_1_0_0_0};
      tbl[5]  = '{7'b1_1_1_10_0_0, 9'b0001_1_1_0_0_0};
      tbl[6]  = '{7'b0_0_1_00_0_0, 9'b0000_1_0_1_1_0};
      tbl[7]  = '{7'b0_0_1_00_0_0, 9'b0000_1_0_1_1_0};
      tbl[8]  = '{7'b0_0_0_00_0_1, 9'b0000_1_0_0_0_0};
      tbl[9]  = '{7'b1_1_0_00_0_0, 9'b0001_1_1_0_0_0};
      tbl[10] = '{7'b0_0_1_01_0_0, 9'b0000_1_0_1_0_0};
      tbl[11] = '{7'b0_0_0_00_0_1, 9'b0000_1_0_0_0_0};
      tbl[12] = '{7'b1_1_0_00_0_0, 9'b0001_1_1_0_0_0};
      tbl[13] = '{7'b0_0_1_11_1_0, 9'b0000_1_0_1_1_1};
      tbl[14] = '{7'b0_0_0_00_0_1, 9'b0000_1_0_0_0_1};
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].in);
         cycle();
         check($sformatf("tbl%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
      end
      drive(7'b0);

      // Fill to MAX_OUTSTD, then one pop frees a slot.
      for (int i = 0; i < MaxOutstd; i++) begin
         drive((i == MaxOutstd - 1) ? 7'b1_1_0_00_0_0 : 7'b1_0_0_00_0_0);
         cycle();
      end
      drive(7'b0);
      check("full_cnt", 32'(bus.outstd_cnt), 32'd8);
      check("full_rdy", 32'(bus.atx_issue_rdy), 32'd0);
      drive(7'b0_0_1_00_0_0);
      cycle();
      check("pop_at_full_cnt", 32'(bus.outstd_cnt), 32'd7);
      check("pop_at_full_rdy", 32'(bus.atx_issue_rdy), 32'd1);
      drain();

      // Simultaneous push and pop at three outstanding.
      for (int i = 0; i < 3; i++) begin
         drive(7'b1_0_0_00_0_0);
         cycle();
      end
      drive(7'b1_1_1_00_0_0);
      cycle();
      check("push_pop_cnt", 32'(bus.outstd_cnt), 32'd3);
      drain();

      // Twenty bursts, last every fifth, random pacing across pointer wraps.
      ndone  = 0;
      issued = 0;
      for (int i = 0; i < 1000 && (issued < 20 || fq.size() != 0 || dv_m); i++) begin
         st = (issued < 20) && rdy_m && bus.atx_issue_rdy && 1'($urandom % 2);
         l  = (issued % 5 == 4);
         bv = 1'($urandom % 2);
         dr = 1'($urandom % 2);
         if (st) issued++;
         drive({st, l, bv, 2'b00, 1'b0, dr});
         cycle();
      end
      drive(7'b0);
      check("wrap_done_cnt", 32'(ndone), 32'd4);

      // Pending completion blocks bready until consumed.
      drive(7'b1_1_0_00_0_0);
      cycle();
      drive(7'b1_1_1_00_0_0);
      cycle();
      for (int i = 0; i < 4; i++) begin
         drive(7'b0_0_1_00_0_0);
         cycle();
         check("hold_bready", 32'(bus.bready), 32'd0);
         check("hold_done", 32'({bus.tx_done_vld, bus.tx_done_err}), 32'd2);
      end
      drive(7'b0_0_1_00_0_1);
      cycle();
      check("release_done", 32'(bus.tx_done_vld), 32'd0);
      check("release_bready", 32'(bus.bready), 32'd1);
      drain();

      // Asynchronous reset with three outstanding.
      for (int i = 0; i < 3; i++) begin
         drive(7'b1_0_0_00_0_0);
         cycle();
      end
      check("pre_rst_cnt", 32'(bus.outstd_cnt), 32'd3);
      apply_reset();
      check("post_rst", 32'({bus.atx_issue_rdy, bus.outstd_cnt}), 32'h10);

      // Random traffic against the model, with one reset part way through.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) apply_reset();
         st  = rdy_m && bus.atx_issue_rdy && 1'($urandom % 2);
         l   = ($urandom % 3) == 0;
         bv  = 1'($urandom % 2);
         br  = 2'($urandom % 4);
         bad = ($urandom % 16) == 0;
         dr  = 1'($urandom % 2);
         drive({st, l, bv, br, bad, dr});
         cycle();
      end
      drive(7'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
